// File: rtl/uart_rx_if.sv
// Serial line, oversample tick and received-byte outputs of uart_rx.
// master = the receiver; slave = the side that drives the line/tick and consumes bytes.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tick_i;
  logic                 rx_i;
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 frame_err_o;
  logic                 parity_err_o;
  logic                 busy_o;

  modport master (
    input  tick_i, rx_i,
    output data_o, valid_o, frame_err_o, parity_err_o, busy_o
  );

  modport slave (
    output tick_i, rx_i,
    input  data_o, valid_o, frame_err_o, parity_err_o, busy_o
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampled UART receiver (start + DATA_BITS + [parity] + stop); pulses 1 clk after the mid-stop tick, no backpressure.
// Optional parity bit and parity_err_o are enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_WAIT_HI = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY  = 3'd5
`endif
  } state_t;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  state_t               r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_busy;
  logic                 w_at_mid_start;
  logic                 w_at_mid_bit;
  logic                 w_par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx_i;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_at_mid_start = (r_tick_cnt == TICK_MID);
  assign w_at_mid_bit   = (r_tick_cnt == TICK_END);

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;

  assign w_par_bad = ((^r_shreg) ^ r_par_bit) != PARITY_ODD[0];
  assign bus.parity_err_o = r_parity_err;
`else
  logic w_unused_parity_odd;

  assign w_unused_parity_odd = PARITY_ODD[0];
  assign w_par_bad           = 1'b0;
  assign bus.parity_err_o    = 1'b0;
`endif

  // Pulse flops are cleared every clk so each pulse lasts one clk independent of tick_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (bus.tick_i) begin
        case (r_state)
          S_IDLE: begin
            if (!r_rx_s) begin
              r_state    <= S_START;
              r_tick_cnt <= '0;
              r_busy     <= 1'b1;
            end
          end

          S_START: begin
            if (w_at_mid_start) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              if (!r_rx_s) begin
                r_state <= S_DATA;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end

          S_DATA: begin
            if (w_at_mid_bit) begin
              r_shreg    <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
              r_tick_cnt <= '0;
              if (r_bit_cnt == BIT_LAST) begin
                r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                r_state   <= S_PARITY;
`else
                r_state   <= S_STOP;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end

`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (w_at_mid_bit) begin
              r_par_bit  <= r_rx_s;
              r_tick_cnt <= '0;
              r_state    <= S_STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
`endif

          S_STOP: begin
            if (w_at_mid_bit) begin
              r_data     <= r_shreg;
              r_tick_cnt <= '0;
              if (!r_rx_s) begin
                r_frame_err <= 1'b1;
                r_state     <= S_WAIT_HI;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
                  r_parity_err <= 1'b1;
`endif
                end else begin
                  r_valid <= 1'b1;
                end
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end

          // Line held low (break or bad stop): wait for it to return high.
          S_WAIT_HI: begin
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end

          default: begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_o      = r_data;
  assign bus.valid_o     = r_valid;
  assign bus.frame_err_o = r_frame_err;
  assign bus.busy_o      = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed frames against a queue-based frame model of uart_rx.
// Tick every 4 clk, OVERSAMPLE=16 -> one bit period is 64 clk.
module tb_uart_rx;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int PARITY_ODD = 0;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CLK    = OVERSAMPLE * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  localparam int K_VALID = 0;
  localparam int K_FRAME = 1;
  localparam int K_PAR   = 2;

  logic clk;
  logic rst_n;

  uart_rx_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_rx #(
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS (DATA_BITS),
    .PARITY_ODD(PARITY_ODD)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         exp_kind[$];
  logic [7:0] exp_data[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bus.tick_i = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      bus.tick_i = 1'b1;
      @(negedge clk);
      bus.tick_i = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic hold_line(input logic v, input int nclk);
    bus.rx_i = v;
    repeat (nclk) @(negedge clk);
  endtask

  // Expected outcome is pushed before the stop bit so the monitor can match it.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    logic par;
    hold_line(1'b0, BIT_CLK);
    for (int i = 0; i < DATA_BITS; i++) hold_line(d[i], BIT_CLK);
    par = (^d) ^ PARITY_ODD[0] ^ par_flip;
    if (PARITY_ON) hold_line(par, BIT_CLK);
    if (!stop)                      exp_kind.push_back(K_FRAME);
    else if (PARITY_ON && par_flip) exp_kind.push_back(K_PAR);
    else                            exp_kind.push_back(K_VALID);
    exp_data.push_back(d);
    hold_line(stop, BIT_CLK);
    check("result_by_end_of_stop", exp_kind.size(), 0);
  endtask

  // Every output pulse is matched against the oldest expected frame outcome.
  initial begin
    int         npulse;
    int         got_kind;
    int         k;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      npulse = int'(bus.valid_o) + int'(bus.frame_err_o) + int'(bus.parity_err_o);
      if (npulse != 0) begin
        check("pulse_onehot", npulse, 1);
        got_kind = bus.valid_o ? K_VALID : (bus.frame_err_o ? K_FRAME : K_PAR);
        if (exp_kind.size() == 0) begin
          check("unexpected_pulse", {bus.valid_o, bus.frame_err_o, bus.parity_err_o}, 0);
        end else begin
          k = exp_kind.pop_front();
          d = exp_data.pop_front();
          check("pulse_kind", got_kind, k);
          check("data_o", bus.data_o, d);
        end
      end
    end
  end

  initial begin
    logic       busy_seen;
    logic [7:0] d;
    logic       stop;
    logic       flip;

    rst_n    = 1'b0;
    bus.rx_i = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_data", bus.data_o, 0);
    check("rst_busy", bus.busy_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_data", bus.data_o, 0);
    check("post_rst_valid", bus.valid_o, 0);
    check("post_rst_ferr", bus.frame_err_o, 0);
    check("post_rst_perr", bus.parity_err_o, 0);
    busy_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      busy_seen |= bus.busy_o;
    end
    check("idle_busy", busy_seen, 0);

    send_frame(8'hA5, 1'b1, 1'b0);
    hold_line(1'b1, BIT_CLK);
    check("busy_after_a5", bus.busy_o, 0);

    // Glitch shorter than half a bit: false start.
    busy_seen = 1'b0;
    bus.rx_i  = 1'b0;
    for (int i = 0; i < 5 * TICK_DIV; i++) begin
      @(negedge clk);
      busy_seen |= bus.busy_o;
    end
    bus.rx_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      busy_seen |= bus.busy_o;
    end
    check("false_start_busy_rose", busy_seen, 1);
    hold_line(1'b1, BIT_CLK);
    check("false_start_busy_fell", bus.busy_o, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold_line(1'b1, 37);

    send_frame(8'h3C, 1'b0, 1'b0);
    hold_line(1'b0, 40 * TICK_DIV);
    check("busy_in_break", bus.busy_o, 1);
    hold_line(1'b1, BIT_CLK);
    send_frame(8'h55, 1'b1, 1'b0);
    hold_line(1'b1, 11);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    hold_line(1'b1, BIT_CLK);

    // Reset three data bits into 0x81.
    hold_line(1'b0, BIT_CLK);
    hold_line(1'b1, BIT_CLK);
    hold_line(1'b0, BIT_CLK);
    hold_line(1'b0, BIT_CLK);
    rst_n    = 1'b0;
    bus.rx_i = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_busy", bus.busy_o, 0);
    rst_n = 1'b1;
    hold_line(1'b1, 2 * BIT_CLK);
    send_frame(8'h81, 1'b1, 1'b0);
    hold_line(1'b1, BIT_CLK);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h81, 1'b1, 1'b1);
    hold_line(1'b1, BIT_CLK);
`endif

    for (int n = 0; n < 20; n++) begin
      hold_line(1'b1, $urandom_range(0, 150));
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      flip = PARITY_ON && ($urandom_range(0, 3) == 0);
      send_frame(d, stop, flip);
      if (!stop) begin
        hold_line(1'b0, TICK_DIV * $urandom_range(0, 40));
        hold_line(1'b1, BIT_CLK);
      end
    end

    hold_line(1'b1, 4 * BIT_CLK);
    check("all_frames_reported", exp_kind.size(), 0);
    check("final_busy", bus.busy_o, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
